sync_frame_tx: RTL and testbench
================================

// Module: sync_frame_tx
// PURPOSE
//   Bit-serial frame transmitter; the sending end of the team's serial sync-word link.
//   Accepts a parallel DATA_W-bit word over a valid/ready handshake and emits one frame, MSB first:
//   SYNC_W sync bits (SYNC), then DATA_W payload bits, then GAP idle bits.
//   Outputs are Moore style: a function of state and registers only, never of the inputs.
//   Feeds the serial 1001 sequence detector and the other link receivers.
// PARAMETERS
//   DATA_W  8        payload width in bits, >= 1
//   SYNC_W  4        sync word width in bits, >= 1
//   SYNC    4'b1001  sync pattern, sent MSB first
//   GAP     2        idle bit-times after each frame, >= 0
// PORTS
//   clk         in   1       clock; all logic on posedge
//   rst         in   1       synchronous reset, active-high
//   in_valid    in   1       in_data is valid
//   in_data     in   DATA_W  payload word to send
//   in_ready    out  1       block can accept a word; high only in IDLE
//   dout        out  1       serial bit
//   dout_valid  out  1       dout carries a frame bit (sync or payload)
//   busy        out  1       high in any state other than IDLE
//   frame_done  out  1       one-cycle pulse, high while the last payload bit is on dout
// BEHAVIOUR
//   States: IDLE, SYNC, DATA, GUARD. Bit counter is clog2(max(SYNC_W, DATA_W, GAP, 2)) bits wide.
//   Reset: sync reset is taken at the clock edge; in the next cycle all of these hold:
//     state=IDLE, counter=0, shift reg=0, dout=0, dout_valid=0, busy=0, frame_done=0, in_ready=1.
//   Reset dominates every other event. A frame in progress is abandoned and no partial bits resume.
//   IDLE
//     in_ready=1, dout=0, dout_valid=0.
//     An edge with in_valid=1 captures in_data into the shift reg, sets cnt=0 and moves to SYNC.
//   SYNC
//     dout=SYNC[SYNC_W-1-cnt], dout_valid=1.
//     After the bit with cnt=SYNC_W-1, moves to DATA with cnt=0.
//   DATA
//     dout=shift[DATA_W-1], dout_valid=1; shifts left by 1 at every edge.
//     frame_done=1 when cnt=DATA_W-1.
//     Next state is GUARD (cnt=0) when GAP>0, otherwise IDLE.
//   GUARD
//     dout=0, dout_valid=0, busy=1.
//     GAP cycles, then moves to IDLE.
//   Latency: the first sync bit is on dout in the cycle after the accepting edge.
//   Frame period: SYNC_W+DATA_W+GAP+1 cycles, including one mandatory IDLE cycle.
//   in_valid outside IDLE is ignored and never queued. in_data is don't-care after capture.
//   dout=0 whenever dout_valid=0.
// TESTING
//   1 Reset: assert rst 2 cycles in mid-DATA.
//     -> next cycle IDLE, dout=0, dout_valid=0, in_ready=1, busy=0.
//   2 Single frame: defaults, in_data=8'hA5 accepted at edge 0.
//     -> cycles 1-12 dout = 1,0,0,1, 1,0,1,0,0,1,0,1 with dout_valid=1.
//     -> frame_done only in cycle 12.
//     -> cycles 13-14 dout_valid=0; in_ready=1 in cycle 15.
//   3 Back-to-back: in_valid held high with 8'hFF, then 8'h00.
//     -> accepts at edges 0 and 15 only.
//     -> second frame's sync bits on dout in cycles 16-19.
//   4 Busy ignore: pulse in_valid with 8'h3C in cycle 6 of a frame.
//     -> no capture; the current frame completes unchanged.
//   5 GAP=0, DATA_W=4, in_data=4'h9.
//     -> dout 1,0,0,1,1,0,0,1 in cycles 1-8; in_ready=1 in cycle 9.
//   6 Loopback into the 1001 sequence detector, in_data=8'h00.
//     -> exactly one detector pulse, in cycle 5 (one cycle after the last sync bit).

Source files
------------

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: bit-serial frame transmitter for the sync-word link.
// A parallel word accepted over valid/ready is sent MSB first as
// SYNC_W sync bits, DATA_W payload bits, then GAP idle bit-times.
// All outputs are registered and are a pure function of the registered state
// (they are computed from the next-state values one edge early).
module sync_frame_tx #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1001,
    parameter int                GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done
);

    // Counter must reach the longest phase minus one; never narrower than 1 bit.
    localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_B = (MAX_A > GAP) ? MAX_A : GAP;
    localparam int MAX_C = (MAX_B > 2) ? MAX_B : 2;
    localparam int CNT_W = $clog2(MAX_C);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DATA  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   shift_s;

    logic                in_ready_r;
    logic                dout_r;
    logic                dout_valid_r;
    logic                busy_r;
    logic                frame_done_r;

    logic                in_ready_s;
    logic                dout_s;
    logic                dout_valid_s;
    logic                busy_s;
    logic                frame_done_s;

    // Sync bit for a given position, MSB of the pattern first; shifting avoids
    // a variable part-select on the parameter.
    function automatic logic sync_bit(input logic [CNT_W-1:0] idx);
        logic [SYNC_W-1:0] tmp;
        tmp      = SYNC << idx;
        sync_bit = tmp[SYNC_W-1];
    endfunction

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_SYNC;
                    cnt_s   = CNT_ZERO;
                    shift_s = in_data;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (cnt_r == SYNC_LAST) begin
                    state_s = ST_DATA;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                shift_s = shift_r << 1;
                if (cnt_r == DATA_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (GAP > 0) begin
                        state_s = ST_GUARD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_GUARD: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                shift_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Output decode of the upcoming state so the registered outputs line up with it.
    always_comb begin
        in_ready_s   = 1'b0;
        dout_s       = 1'b0;
        dout_valid_s = 1'b0;
        busy_s       = 1'b1;
        frame_done_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_SYNC: begin
                dout_s       = sync_bit(cnt_s);
                dout_valid_s = 1'b1;
            end
            ST_DATA: begin
                dout_s       = shift_s[DATA_W-1];
                dout_valid_s = 1'b1;
                frame_done_s = (cnt_s == DATA_LAST);
            end
            ST_GUARD: begin
                dout_s       = 1'b0;
                dout_valid_s = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            shift_r      <= {DATA_W{1'b0}};
            in_ready_r   <= 1'b1;
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            shift_r      <= shift_s;
            in_ready_r   <= in_ready_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default instance (8-bit payload, GAP=2)
// and a GAP=0 / 4-bit instance, plus a small 1001 detector on the serial line.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid_a;
    logic [7:0] in_data_a;
    logic       in_ready_a, dout_a, dout_valid_a, busy_a, frame_done_a;

    logic       in_valid_b;
    logic [3:0] in_data_b;
    logic       in_ready_b, dout_b, dout_valid_b, busy_b, frame_done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC(4'b1001), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .dout(dout_a), .dout_valid(dout_valid_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    sync_frame_tx #(.DATA_W(4), .SYNC_W(4), .SYNC(4'b1001), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    // Reference 1001 sequence detector (Moore, registered pulse) fed by dout_a.
    logic [2:0] det_hist;
    logic       det_pulse;
    always_ff @(posedge clk) begin
        if (rst) begin
            det_hist  <= 3'b000;
            det_pulse <= 1'b0;
        end else begin
            det_hist  <= {det_hist[1:0], dout_a};
            det_pulse <= ({det_hist, dout_a} == 4'b1001);
        end
    end

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = {in_ready_a, dout_a, dout_valid_a, busy_a, frame_done_a};
        n_tests++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_a rdy/dout/vld/busy/done got %b want 10000", got);
        end
        got = {in_ready_b, dout_b, dout_valid_b, busy_b, frame_done_b};
        n_tests++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_b rdy/dout/vld/busy/done got %b want 10000", got);
        end
        rst = 1'b0;
        // Start a frame, then reset in mid-DATA with in_valid also high.
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 8'hA5;
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({dout_valid_a, busy_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_pre_middata vld/busy got %b want 11", {dout_valid_a, busy_a});
        end
        rst        = 1'b1;
        in_valid_a = 1'b1;
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            got = {in_ready_a, dout_a, dout_valid_a, busy_a, frame_done_a};
            n_tests++;
            if (got !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_middata c=%0d rdy/dout/vld/busy/done got %b want 10000", c, got);
            end
            if (c == 8) begin
                rst        = 1'b0;
                in_valid_a = 1'b0;
            end
        end
    endtask

    task automatic test_single_frame();
        logic [11:0] exp_sr;
        logic        exp_v;
        exp_sr = {4'b1001, 8'hA5};
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 8'hA5;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) in_valid_a = 1'b0;
            exp_v = (c <= 12);
            n_tests++;
            if (dout_valid_a !== exp_v) begin
                n_fail++;
                $display("FAIL single_valid c=%0d got %b want %b", c, dout_valid_a, exp_v);
            end
            n_tests++;
            if (dout_a !== (exp_v & exp_sr[11])) begin
                n_fail++;
                $display("FAIL single_dout c=%0d got %b want %b", c, dout_a, exp_v & exp_sr[11]);
            end
            if (exp_v) exp_sr = exp_sr << 1;
            n_tests++;
            if (frame_done_a !== (c == 12)) begin
                n_fail++;
                $display("FAIL single_done c=%0d got %b want %b", c, frame_done_a, (c == 12));
            end
            n_tests++;
            if ({in_ready_a, busy_a} !== ((c == 15) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL single_rdy_busy c=%0d got %b", c, {in_ready_a, busy_a});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp1;
        logic [11:0] exp2;
        logic        exp_v;
        exp1 = {4'b1001, 8'hFF};
        exp2 = {4'b1001, 8'h00};
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 8'hFF;
        n_tests++;
        if (in_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready c=0 got %b want 1", in_ready_a);
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1)  in_data_a  = 8'h00;
            if (c == 16) in_valid_a = 1'b0;
            n_tests++;
            if (in_ready_a !== (c == 15 || c == 30)) begin
                n_fail++;
                $display("FAIL b2b_ready c=%0d got %b want %b", c, in_ready_a, (c == 15 || c == 30));
            end
            exp_v = (c <= 12) || (c >= 16 && c <= 27);
            n_tests++;
            if (dout_valid_a !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_valid c=%0d got %b want %b", c, dout_valid_a, exp_v);
            end
            if (c <= 12) begin
                n_tests++;
                if (dout_a !== exp1[11]) begin
                    n_fail++;
                    $display("FAIL b2b_dout1 c=%0d got %b want %b", c, dout_a, exp1[11]);
                end
                exp1 = exp1 << 1;
            end else if (c >= 16 && c <= 27) begin
                n_tests++;
                if (dout_a !== exp2[11]) begin
                    n_fail++;
                    $display("FAIL b2b_dout2 c=%0d got %b want %b", c, dout_a, exp2[11]);
                end
                exp2 = exp2 << 1;
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [11:0] exp_sr;
        logic        exp_v;
        exp_sr = {4'b1001, 8'hC3};
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 8'hC3;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) in_valid_a = 1'b0;
            exp_v = (c <= 12);
            n_tests++;
            if (dout_valid_a !== exp_v || dout_a !== (exp_v & exp_sr[11])) begin
                n_fail++;
                $display("FAIL ignore_dout c=%0d got vld=%b dout=%b want vld=%b dout=%b",
                         c, dout_valid_a, dout_a, exp_v, exp_v & exp_sr[11]);
            end
            if (exp_v) exp_sr = exp_sr << 1;
            n_tests++;
            if ({in_ready_a, busy_a} !== ((c >= 15) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL ignore_rdy_busy c=%0d got %b", c, {in_ready_a, busy_a});
            end
            if (c == 6) begin
                in_valid_a = 1'b1;
                in_data_a  = 8'h3C;
            end
            if (c == 7) in_valid_a = 1'b0;
        end
    endtask

    task automatic test_gap0();
        logic [7:0] exp_sr;
        logic       exp_v;
        exp_sr = {4'b1001, 4'h9};
        @(negedge clk);
        in_valid_b = 1'b1;
        in_data_b  = 4'h9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) in_valid_b = 1'b0;
            exp_v = (c <= 8);
            n_tests++;
            if (dout_valid_b !== exp_v || dout_b !== (exp_v & exp_sr[7])) begin
                n_fail++;
                $display("FAIL gap0_dout c=%0d got vld=%b dout=%b want vld=%b dout=%b",
                         c, dout_valid_b, dout_b, exp_v, exp_v & exp_sr[7]);
            end
            if (exp_v) exp_sr = exp_sr << 1;
            n_tests++;
            if ({in_ready_b, busy_b, frame_done_b} !== {(c >= 9), (c <= 8), (c == 8)}) begin
                n_fail++;
                $display("FAIL gap0_rdy_busy_done c=%0d got %b want %b", c,
                         {in_ready_b, busy_b, frame_done_b}, {(c >= 9), (c <= 8), (c == 8)});
            end
        end
    endtask

    task automatic test_detector_loopback();
        int pulses;
        pulses = 0;
        repeat (4) @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 8'h00;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) in_valid_a = 1'b0;
            if (det_pulse === 1'b1) pulses++;
            n_tests++;
            if (det_pulse !== (c == 5)) begin
                n_fail++;
                $display("FAIL loop_pulse c=%0d got %b want %b", c, det_pulse, (c == 5));
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL loop_pulse_count got %0d want 1", pulses);
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (!(in_ready_a === 1'b1 && in_ready_b === 1'b1) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle timeout rdy_a=%b rdy_b=%b", in_ready_a, in_ready_b);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_data_a  = 8'h00;
        in_valid_b = 1'b0;
        in_data_b  = 4'h0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        wait_idle();
        test_busy_ignore();
        wait_idle();
        test_gap0();
        wait_idle();
        test_detector_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
